// File: rtl/ls_unit.sv
//==============================================================================
// Module  : ls_unit
// Purpose : Load/store execution unit. Accepts one issue at a time from the LS
//           buffer and runs it over a byte-serial memory port (one byte per
//           memAck). Load results are sign- or zero-extended and broadcast
//           with their tag for a single DONE cycle.
// Ports   : clk, rst (async, active-low)
//           LSworkEn, operandO, operandT, imm, wrtTag, wrtName, opCode  - issue
//           LSreadEn, LSdone, enLSwrt, LStag, LSdata, LSmisalign     - status
//           memReq, memWrt, memAddr, memWdata, memAck, memRdata      - memory
// Config  : `define LS_MISALIGN_TRAP_EN to trap misaligned halfword/word
//           accesses (no memory traffic, LSmisalign pulses with LSdone).
//           Left undefined, misaligned accesses run byte-serially.
//           ADDR_W must not exceed 32.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

`ifndef DataBus
`define DataBus 31:0
`endif
`ifndef TagBus
`define TagBus 3:0
`endif
`ifndef NameBus
`define NameBus 4:0
`endif
`ifndef OpBus
`define OpBus 5:0
`endif
`ifndef tagFree
`define tagFree 4'h0
`endif
`ifndef dataFree
`define dataFree 32'h0
`endif

module ls_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              LSworkEn,
  input  logic [`DataBus]   operandO,
  input  logic [`DataBus]   operandT,
  input  logic [`DataBus]   imm,
  input  logic [`TagBus]    wrtTag,
  input  logic [`NameBus]   wrtName,
  input  logic [`OpBus]     opCode,
  output logic              LSreadEn,
  output logic              LSdone,
  output logic              enLSwrt,
  output logic [`TagBus]    LStag,
  output logic [`DataBus]   LSdata,
  output logic              LSmisalign,
  output logic              memReq,
  output logic              memWrt,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memWdata,
  input  logic              memAck,
  input  logic [7:0]        memRdata
);

  localparam logic [5:0] OP_LB  = 6'h01;
  localparam logic [5:0] OP_LH  = 6'h02;
  localparam logic [5:0] OP_LW  = 6'h03;
  localparam logic [5:0] OP_LBU = 6'h04;
  localparam logic [5:0] OP_LHU = 6'h05;
  localparam logic [5:0] OP_SB  = 6'h06;
  localparam logic [5:0] OP_SH  = 6'h07;
  localparam logic [5:0] OP_SW  = 6'h08;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [1:0]      k_q;        // byte index within the access
  logic [1:0]      last_q;     // index of the final byte (n-1)
  logic            load_q;
  logic            sext_q;
  logic [31:0]     ea_q;
  logic [31:0]     wdata_q;
  logic [31:0]     result_q;
  logic [`TagBus]  tag_q;
  logic [`NameBus] name_q;
  logic            done_q;
  logic            enwrt_q;
  logic            misalign_q;
  logic [`TagBus]  lstag_q;
  logic [31:0]     lsdata_q;

  // Opcode decode
  logic       dec_valid;
  logic       dec_load;
  logic       dec_sext;
  logic [1:0] dec_last;

  always_comb begin
    dec_valid = 1'b1;
    dec_load  = 1'b0;
    dec_sext  = 1'b0;
    dec_last  = 2'd0;
    case (opCode)
      OP_LB:  begin dec_load = 1'b1; dec_sext = 1'b1; end
      OP_LBU: begin dec_load = 1'b1; end
      OP_LH:  begin dec_load = 1'b1; dec_sext = 1'b1; dec_last = 2'd1; end
      OP_LHU: begin dec_load = 1'b1; dec_last = 2'd1; end
      OP_LW:  begin dec_load = 1'b1; dec_last = 2'd3; end
      OP_SB:  begin end
      OP_SH:  begin dec_last = 2'd1; end
      OP_SW:  begin dec_last = 2'd3; end
      default: dec_valid = 1'b0;
    endcase
  end

  logic [31:0] ea_d;
  assign ea_d = operandO + imm;

  logic trap_d;
`ifdef LS_MISALIGN_TRAP_EN
  assign trap_d = dec_valid && (((dec_last == 2'd1) && ea_d[0]) ||
                                ((dec_last == 2'd3) && (ea_d[1:0] != 2'b00)));
`else
  assign trap_d = 1'b0;
`endif

  // Result with the byte arriving this cycle merged in, so the final byte
  // can be extended and registered on the same edge that enters DONE.
  logic [31:0] result_d;
  always_comb begin
    result_d = result_q;
    case (k_q)
      2'd0: result_d[7:0]   = memRdata;
      2'd1: result_d[15:8]  = memRdata;
      2'd2: result_d[23:16] = memRdata;
      default: result_d[31:24] = memRdata;
    endcase
  end

  logic [31:0] ext_d;
  always_comb begin
    case (last_q)
      2'd0:    ext_d = sext_q ? {{24{result_d[7]}}, result_d[7:0]}
                              : {24'h0, result_d[7:0]};
      2'd1:    ext_d = sext_q ? {{16{result_d[15]}}, result_d[15:0]}
                              : {16'h0, result_d[15:0]};
      default: ext_d = result_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      last_q     <= 2'd0;
      load_q     <= 1'b0;
      sext_q     <= 1'b0;
      ea_q       <= 32'h0;
      wdata_q    <= 32'h0;
      result_q   <= 32'h0;
      tag_q      <= `tagFree;
      name_q     <= '0;
      done_q     <= 1'b0;
      enwrt_q    <= 1'b0;
      misalign_q <= 1'b0;
      lstag_q    <= `tagFree;
      lsdata_q   <= `dataFree;
    end else begin
      case (state_q)
        IDLE: begin
          if (LSworkEn) begin
            tag_q    <= wrtTag;
            name_q   <= wrtName;
            wdata_q  <= operandT;
            ea_q     <= ea_d;
            k_q      <= 2'd0;
            last_q   <= dec_last;
            load_q   <= dec_load;
            sext_q   <= dec_sext;
            result_q <= 32'h0;
            // Unknown opcodes and trapped misaligned accesses skip memory.
            if (!dec_valid || trap_d) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              misalign_q <= trap_d;
            end else begin
              state_q <= XFER;
            end
          end
        end
        XFER: begin
          if (memAck) begin
            result_q <= result_d;
            k_q      <= k_q + 2'd1;
            if (k_q == last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              enwrt_q <= load_q;
              if (load_q) begin
                lstag_q  <= tag_q;
                lsdata_q <= ext_d;
              end
            end
          end
        end
        DONE: begin
          state_q    <= IDLE;
          k_q        <= 2'd0;
          done_q     <= 1'b0;
          enwrt_q    <= 1'b0;
          misalign_q <= 1'b0;
          lstag_q    <= `tagFree;
          lsdata_q   <= `dataFree;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port: driven only while transferring, zero otherwise.
  logic [31:0] addr_full;
  logic [31:0] wshift;
  assign addr_full = ea_q + {30'h0, k_q};
  assign wshift    = wdata_q >> {k_q, 3'b000};

  assign memReq   = (state_q == XFER);
  assign memWrt   = memReq & ~load_q;
  assign memAddr  = memReq ? addr_full[ADDR_W-1:0] : '0;
  assign memWdata = memReq ? wshift[7:0] : 8'h00;

  assign LSreadEn   = (state_q == IDLE) & ~LSworkEn;
  assign LSdone     = done_q;
  assign enLSwrt    = enwrt_q;
  assign LStag      = lstag_q;
  assign LSdata     = lsdata_q;
  assign LSmisalign = misalign_q;

  // The issuing name is latched with the operation but not consumed here.
  logic unused_name;
  assign unused_name = ^name_q;

endmodule

`default_nettype wire

// File: tb/tb_ls_unit.sv
`default_nettype none

module tb_ls_unit;

  localparam logic [5:0] OP_LB  = 6'h01;
  localparam logic [5:0] OP_LH  = 6'h02;
  localparam logic [5:0] OP_LW  = 6'h03;
  localparam logic [5:0] OP_LBU = 6'h04;
  localparam logic [5:0] OP_LHU = 6'h05;
  localparam logic [5:0] OP_SB  = 6'h06;
  localparam logic [5:0] OP_SH  = 6'h07;
  localparam logic [5:0] OP_SW  = 6'h08;
  localparam logic [5:0] OP_BAD = 6'h3F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        LSworkEn = 1'b0;
  logic [31:0] operandO = '0, operandT = '0, imm = '0;
  logic [3:0]  wrtTag = '0;
  logic [4:0]  wrtName = '0;
  logic [5:0]  opCode = '0;
  logic        LSreadEn, LSdone, enLSwrt, LSmisalign;
  logic [3:0]  LStag;
  logic [31:0] LSdata;
  logic        memReq, memWrt;
  logic [31:0] memAddr;
  logic [7:0]  memWdata;
  logic        memAck = 1'b0;
  logic [7:0]  memRdata = '0;

  ls_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .LSworkEn(LSworkEn),
    .operandO(operandO), .operandT(operandT), .imm(imm),
    .wrtTag(wrtTag), .wrtName(wrtName), .opCode(opCode),
    .LSreadEn(LSreadEn), .LSdone(LSdone), .enLSwrt(enLSwrt),
    .LStag(LStag), .LSdata(LSdata), .LSmisalign(LSmisalign),
    .memReq(memReq), .memWrt(memWrt), .memAddr(memAddr),
    .memWdata(memWdata), .memAck(memAck), .memRdata(memRdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference memory and model ----------------
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic int nbytes(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic bit is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] ea);
    logic [31:0] w;
    w = {rd(ea + 32'd3), rd(ea + 32'd2), rd(ea + 32'd1), rd(ea)};
    case (op)
      OP_LB:  return w[7]  ? (32'hFFFFFF00 | {24'h0, w[7:0]})  : {24'h0, w[7:0]};
      OP_LBU: return {24'h0, w[7:0]};
      OP_LH:  return w[15] ? (32'hFFFF0000 | {16'h0, w[15:0]}) : {16'h0, w[15:0]};
      OP_LHU: return {16'h0, w[15:0]};
      OP_LW:  return w;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- one complete operation ----------------
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] im,
                        input logic [31:0] t, input logic [3:0] tag, input int delay,
                        input int exp_n, input bit exp_en, input logic [31:0] exp_data,
                        input bit exp_mis, input bit hold);
    logic [31:0] ea, sh;
    int cyc, bi, wc;
    bit finished, st;
    ea = a + im;
    st = is_store(op);
    cyc = 0; bi = 0; wc = 0; finished = 0;
    @(negedge clk);
    memAck = 1'b0;
    chk("readen_before_issue", {31'h0, LSreadEn}, 32'd1);
    LSworkEn = 1'b1; opCode = op; operandO = a; imm = im; operandT = t;
    wrtTag = tag; wrtName = 5'($urandom);
    while (!finished && cyc < 200) begin
      @(negedge clk);
      cyc++;
      memAck = 1'b0;
      if (cyc == 1) chk("readen_busy", {31'h0, LSreadEn}, 32'd0);
      if (cyc == (hold ? 2 : 1)) LSworkEn = 1'b0;
      if (memReq) begin
        if (bi >= exp_n) begin
          chk("unexpected_memreq", {31'h0, memReq}, 32'd0);
        end else begin
          sh = t >> (8 * bi);
          chk("memAddr", memAddr, ea + 32'(bi));
          chk("memWrt", {31'h0, memWrt}, {31'h0, st});
          if (st) chk("memWdata", {24'h0, memWdata}, {24'h0, sh[7:0]});
          if (wc == delay) begin
            memAck = 1'b1;
            memRdata = rd(ea + 32'(bi));
            if (st) mem[ea + 32'(bi)] = sh[7:0];
            bi++;
            wc = 0;
          end else begin
            memRdata = 8'($urandom);
            wc++;
          end
        end
      end else begin
        chk("idle_port_zero", {memAddr[23:0], memWdata}, 32'h0);
        chk("idle_memWrt", {31'h0, memWrt}, 32'd0);
      end
      if (LSdone) begin
        finished = 1;
        chk("bytes_transferred", 32'(bi), 32'(exp_n));
        chk("latency", 32'(cyc), 32'(exp_n * (delay + 1) + 1));
        chk("enLSwrt", {31'h0, enLSwrt}, {31'h0, exp_en});
        chk("LStag", {28'h0, LStag}, exp_en ? {28'h0, tag} : 32'h0);
        chk("LSdata", LSdata, exp_data);
        chk("LSmisalign", {31'h0, LSmisalign}, {31'h0, exp_mis});
      end
    end
    LSworkEn = 1'b0;
    memAck = 1'b0;
    if (!finished) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("done_pulse_one_cycle", {31'h0, LSdone}, 32'd0);
    chk("readen_after_done", {31'h0, LSreadEn}, 32'd1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, im, t;
    logic [3:0]  tag;
    int          delay;
    int          n;
    bit          en;
    logic [31:0] data;
    bit          mis;
  } vec_t;

  vec_t vt[11];

  logic [5:0] ops [9];

  initial begin
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_BAD};
    mem[32'h104] = 8'h11; mem[32'h105] = 8'h22;
    mem[32'h106] = 8'h33; mem[32'h107] = 8'h84;
    mem[32'h20]  = 8'h80;

    vt[0]  = '{OP_LW,  32'h100, 32'h4, 32'h0,        4'd3,  0, 4, 1'b1, 32'h84332211, 1'b0};
    vt[1]  = '{OP_LB,  32'h20,  32'h0, 32'h0,        4'd5,  0, 1, 1'b1, 32'hFFFFFF80, 1'b0};
    vt[2]  = '{OP_LBU, 32'h1C,  32'h4, 32'h0,        4'd6,  1, 1, 1'b1, 32'h00000080, 1'b0};
    vt[3]  = '{OP_SH,  32'h3C,  32'h4, 32'hA1B2C3D4, 4'd7,  3, 2, 1'b0, 32'h0,        1'b0};
    vt[4]  = '{OP_LHU, 32'h40,  32'h0, 32'h0,        4'd8,  0, 2, 1'b1, 32'h0000C3D4, 1'b0};
    vt[5]  = '{OP_LH,  32'h40,  32'h0, 32'h0,        4'd9,  2, 2, 1'b1, 32'hFFFFC3D4, 1'b0};
`ifdef LS_MISALIGN_TRAP_EN
    vt[6]  = '{OP_LW,  32'h100, 32'h2, 32'h0,        4'd10, 0, 0, 1'b0, 32'h0,        1'b1};
`else
    vt[6]  = '{OP_LW,  32'h100, 32'h2, 32'h0,        4'd10, 0, 4, 1'b1, 32'h22115958, 1'b0};
`endif
    vt[7]  = '{OP_BAD, 32'h300, 32'h0, 32'h0,        4'd11, 0, 0, 1'b0, 32'h0,        1'b0};
    vt[8]  = '{OP_SB,  32'h50,  32'h0, 32'h123456EE, 4'd12, 1, 1, 1'b0, 32'h0,        1'b0};
    vt[9]  = '{OP_LBU, 32'h50,  32'h0, 32'h0,        4'd13, 0, 1, 1'b1, 32'h000000EE, 1'b0};
    vt[10] = '{OP_LB,  32'h4F,  32'h1, 32'h0,        4'd14, 2, 1, 1'b1, 32'hFFFFFFEE, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_memReq", {31'h0, memReq}, 32'd0);
    chk("rst_memWrt", {31'h0, memWrt}, 32'd0);
    chk("rst_LSdone", {31'h0, LSdone}, 32'd0);
    chk("rst_enLSwrt", {31'h0, enLSwrt}, 32'd0);
    chk("rst_LSmisalign", {31'h0, LSmisalign}, 32'd0);
    chk("rst_LStag", {28'h0, LStag}, 32'h0);
    chk("rst_LSdata", LSdata, 32'h0);
    chk("rst_memAddr", memAddr, 32'h0);
    chk("rst_memWdata", {24'h0, memWdata}, 32'h0);
    rst = 1'b1;
    #1;
    chk("readen_after_reset", {31'h0, LSreadEn}, 32'd1);

    for (int i = 0; i < 11; i++)
      run_op(vt[i].op, vt[i].a, vt[i].im, vt[i].t, vt[i].tag, vt[i].delay,
             vt[i].n, vt[i].en, vt[i].data, vt[i].mis, 1'b0);

    // LSworkEn held for two cycles: only one access
    run_op(OP_LB, 32'h20, 32'h0, 32'h0, 4'd2, 0, 1, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_no_second_access", {30'h0, memReq, LSdone}, 32'h0);
    end

    // Reset during the second byte of a store word
    @(negedge clk);
    LSworkEn = 1'b1; opCode = OP_SW; operandO = 32'h200; imm = 32'h0;
    operandT = 32'hCAFEBABE; wrtTag = 4'd4;
    @(negedge clk);
    LSworkEn = 1'b0;
    chk("rstx_byte0_addr", memAddr, 32'h200);
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    chk("rstx_byte1_addr", memAddr, 32'h201);
    chk("rstx_byte1_req", {31'h0, memReq}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstx_memReq_drop", {31'h0, memReq}, 32'd0);
    chk("rstx_port_zero", {memAddr[23:0], memWdata}, 32'h0);
    chk("rstx_no_done", {31'h0, LSdone}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstx_readen", {31'h0, LSreadEn}, 32'd1);
    mem[32'h200] = 8'hBE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstx_quiet", {30'h0, memReq, LSdone}, 32'h0);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [5:0]  op;
      logic [31:0] a, im, ea, d;
      int          n;
      bit          mis, en;
      op  = ops[$urandom_range(0, 8)];
      a   = 32'h1000 + 32'($urandom_range(0, 63));
      im  = 32'($urandom_range(0, 15));
      ea  = a + im;
      n   = nbytes(op);
      mis = 1'b0;
`ifdef LS_MISALIGN_TRAP_EN
      if ((n == 2 && ea[0]) || (n == 4 && ea[1:0] != 2'b00)) begin
        n = 0;
        mis = 1'b1;
      end
`endif
      en = is_load(op) && !mis;
      d  = en ? model_load(op, ea) : 32'h0;
      run_op(op, a, im, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2),
             n, en, d, mis, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
